// File: rtl/collision_arbiter.sv
// Per-frame collision arbiter: combinational blocking, once-per-frame event pulses,
// player lives/invulnerability FSM and a saturating kill counter.
module collision_arbiter #(
  parameter int unsigned NUM_ENEMIES   = 2,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned LIVES_W       = 2,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned KILL_W        = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   drawing_request_player,
  input  logic                   drawing_request_columns,
  input  logic                   drawing_request_wall,
  input  logic                   drawing_request_bomb,
  input  logic                   drawing_request_blast,
  input  logic [NUM_ENEMIES-1:0] drawing_request_enemy,
  output logic                   player_block,
  output logic [NUM_ENEMIES-1:0] enemy_block,
  output logic                   collision_blast_wall,
  output logic                   SingleHitPulse_player,
  output logic [NUM_ENEMIES-1:0] enemy_kill_pulse,
  output logic                   wall_break_pulse,
  output logic                   player_invulnerable,
  output logic [LIVES_W-1:0]     lives,
  output logic                   game_over,
  output logic [KILL_W-1:0]      kill_count
);

  localparam int unsigned CntW = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam int unsigned PopW = (NUM_ENEMIES < 2) ? 1 : $clog2(NUM_ENEMIES + 1);
  localparam int unsigned SumW = ((KILL_W > PopW) ? KILL_W : PopW) + 1;

  typedef enum logic [1:0] {StAlive, StInvuln, StDead} state_e;

  state_e                 state_q, state_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [KILL_W-1:0]      kill_q, kill_d;
  logic                   hit_flag_q, wall_flag_q;
  logic [NUM_ENEMIES-1:0] kill_flag_q;
  logic                   hit_pulse_q, wall_pulse_q;
  logic [NUM_ENEMIES-1:0] kill_pulse_q;

  logic                   hit_c, hit_acc, wall_acc;
  logic [NUM_ENEMIES-1:0] kill_c, kill_acc, sof_vec;
  logic [PopW-1:0]        pop;
  logic [SumW-1:0]        sum;

  assign player_block         = drawing_request_player &
                                (drawing_request_columns | drawing_request_wall);
  assign enemy_block          = drawing_request_enemy & {NUM_ENEMIES{drawing_request_columns |
                                drawing_request_wall | drawing_request_bomb}};
  assign collision_blast_wall = drawing_request_blast & drawing_request_wall;

  assign hit_c   = drawing_request_player & (drawing_request_blast | (|drawing_request_enemy));
  assign kill_c  = drawing_request_enemy & {NUM_ENEMIES{drawing_request_blast}};
  assign sof_vec = {NUM_ENEMIES{startOfFrame}};

  // A condition in the startOfFrame cycle belongs to the new frame, so the old flag is ignored.
  assign hit_acc  = hit_c & (state_q == StAlive) & (startOfFrame | ~hit_flag_q);
  assign kill_acc = kill_c & (sof_vec | ~kill_flag_q);
  assign wall_acc = collision_blast_wall & (startOfFrame | ~wall_flag_q);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAlive: begin
        if (hit_acc) begin
          if (lives_q == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = StDead;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
            cnt_d   = CntW'(INVULN_FRAMES);
            state_d = StInvuln;
          end
        end
      end
      StInvuln: begin
        if (startOfFrame) begin
          if (cnt_q == CntW'(1)) begin
            cnt_d   = '0;
            state_d = StAlive;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StDead:  state_d = StDead;
      default: state_d = StAlive;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      pop = pop + PopW'(kill_pulse_q[i]);
    end
    sum    = SumW'(kill_q) + SumW'(pop);
    kill_d = (sum > SumW'({KILL_W{1'b1}})) ? {KILL_W{1'b1}} : sum[KILL_W-1:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StAlive;
      lives_q      <= LIVES_W'(LIVES);
      cnt_q        <= '0;
      kill_q       <= '0;
      hit_flag_q   <= 1'b0;
      wall_flag_q  <= 1'b0;
      kill_flag_q  <= '0;
      hit_pulse_q  <= 1'b0;
      wall_pulse_q <= 1'b0;
      kill_pulse_q <= '0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      cnt_q        <= cnt_d;
      kill_q       <= kill_d;
      hit_flag_q   <= hit_acc | (hit_flag_q & ~startOfFrame);
      wall_flag_q  <= wall_acc | (wall_flag_q & ~startOfFrame);
      kill_flag_q  <= kill_acc | (kill_flag_q & ~sof_vec);
      hit_pulse_q  <= hit_acc;
      wall_pulse_q <= wall_acc;
      kill_pulse_q <= kill_acc;
    end
  end

  assign SingleHitPulse_player = hit_pulse_q;
  assign enemy_kill_pulse      = kill_pulse_q;
  assign wall_break_pulse      = wall_pulse_q;
  assign player_invulnerable   = (state_q == StInvuln);
  assign game_over             = (state_q == StDead);
  assign lives                 = lives_q;
  assign kill_count            = kill_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter with INVULN_FRAMES=2 and KILL_W=2.
module tb_collision_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, pl, col, wl, bm, bl;
  logic [1:0] en;
  logic       player_block, collision_blast_wall, hit_pulse, wall_pulse;
  logic       invuln, game_over;
  logic [1:0] enemy_block, kill_pulse, lives, kill_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  collision_arbiter #(
    .NUM_ENEMIES  (2),
    .LIVES        (3),
    .LIVES_W      (2),
    .INVULN_FRAMES(2),
    .KILL_W       (2)
  ) dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (sof),
    .drawing_request_player (pl),
    .drawing_request_columns(col),
    .drawing_request_wall   (wl),
    .drawing_request_bomb   (bm),
    .drawing_request_blast  (bl),
    .drawing_request_enemy  (en),
    .player_block           (player_block),
    .enemy_block            (enemy_block),
    .collision_blast_wall   (collision_blast_wall),
    .SingleHitPulse_player  (hit_pulse),
    .enemy_kill_pulse       (kill_pulse),
    .wall_break_pulse       (wall_pulse),
    .player_invulnerable    (invuln),
    .lives                  (lives),
    .game_over              (game_over),
    .kill_count             (kill_count)
  );

  task automatic drive(input logic s, p, c, w, b, x, input logic [1:0] e);
    sof = s; pl = p; col = c; wl = w; bm = b; bl = x; en = e;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetN = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00);
    #12;
    chk("rst_lives", 32'(lives), 3);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_invuln", 32'(invuln), 0);
    chk("rst_kill_count", 32'(kill_count), 0);
    chk("rst_hit_pulse", 32'(hit_pulse), 0);
    chk("rst_kill_pulse", 32'(kill_pulse), 0);
    chk("rst_wall_pulse", 32'(wall_pulse), 0);
    resetN = 1'b1;
    cyc();

    // Blocking is combinational and never counts as a hit.
    drive(0, 1, 1, 0, 0, 0, 2'b00); #1;
    chk("player_block_col", 32'(player_block), 1);
    chk("enemy_block_none", 32'(enemy_block), 0);
    cyc();
    chk("no_hit_on_block", 32'(hit_pulse), 0);
    chk("lives_after_block", 32'(lives), 3);
    drive(0, 0, 0, 0, 1, 0, 2'b10); #1;
    chk("enemy1_block_bomb", 32'(enemy_block), 32'h2);
    chk("player_block_off", 32'(player_block), 0);
    cyc();

    // Frame 1: five overlapping pixels give one pulse.
    drive(1, 0, 0, 0, 0, 0, 2'b00); cyc();
    drive(0, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("hit1_pulse", 32'(hit_pulse), 1);
    chk("hit1_lives", 32'(lives), 2);
    chk("hit1_invuln", 32'(invuln), 1);
    cyc();
    chk("hit1_single", 32'(hit_pulse), 0);
    cyc(); cyc(); cyc();
    chk("hit1_tail_pulse", 32'(hit_pulse), 0);
    chk("hit1_tail_lives", 32'(lives), 2);

    // Invulnerable for two frames despite continuous hits.
    drive(1, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("inv_f1_sof_pulse", 32'(hit_pulse), 0);
    chk("inv_f1_invuln", 32'(invuln), 1);
    drive(0, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("inv_f1_pulse", 32'(hit_pulse), 0);
    drive(1, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("inv_f2_sof_pulse", 32'(hit_pulse), 0);
    chk("inv_f2_alive", 32'(invuln), 0);
    chk("inv_f2_lives", 32'(lives), 2);
    drive(0, 0, 0, 0, 0, 0, 2'b00); cyc();
    drive(1, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("hit2_sof_pulse", 32'(hit_pulse), 1);
    chk("hit2_lives", 32'(lives), 1);
    chk("hit2_invuln", 32'(invuln), 1);
    drive(0, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("hit2_single", 32'(hit_pulse), 0);

    // Let invulnerability lapse, then the last life goes.
    drive(1, 0, 0, 0, 0, 0, 2'b00); cyc();
    drive(0, 0, 0, 0, 0, 0, 2'b00); cyc();
    drive(1, 0, 0, 0, 0, 0, 2'b00); cyc();
    chk("lapse_alive", 32'(invuln), 0);
    drive(0, 1, 0, 0, 0, 1, 2'b00); cyc();
    chk("hit3_pulse", 32'(hit_pulse), 1);
    chk("hit3_lives", 32'(lives), 0);
    chk("hit3_game_over", 32'(game_over), 1);
    chk("hit3_invuln", 32'(invuln), 0);
    drive(1, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("dead_sof_pulse", 32'(hit_pulse), 0);
    drive(0, 1, 0, 0, 0, 0, 2'b01); cyc();
    chk("dead_pulse", 32'(hit_pulse), 0);
    chk("dead_stays", 32'(game_over), 1);

    // Kills still counted while dead; counter saturates at 3.
    drive(0, 0, 0, 0, 0, 1, 2'b11); cyc();
    chk("kill2_pulse", 32'(kill_pulse), 32'h3);
    chk("kill2_count_pre", 32'(kill_count), 0);
    drive(0, 0, 0, 0, 0, 0, 2'b00); cyc();
    chk("kill2_count", 32'(kill_count), 2);
    chk("kill2_pulse_off", 32'(kill_pulse), 0);
    drive(1, 0, 0, 0, 0, 1, 2'b11); cyc();
    chk("kill_sof_pulse", 32'(kill_pulse), 32'h3);
    drive(0, 0, 0, 0, 0, 0, 2'b00); cyc();
    chk("kill_sat_count", 32'(kill_count), 3);
    drive(1, 0, 0, 0, 0, 0, 2'b00); cyc();
    drive(0, 0, 0, 0, 0, 1, 2'b01); cyc();
    chk("kill1_pulse", 32'(kill_pulse), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 2'b00); cyc();
    chk("kill_sat_hold", 32'(kill_count), 3);
    drive(0, 0, 0, 0, 0, 1, 2'b01); cyc();
    chk("kill_repeat_frame", 32'(kill_pulse), 0);

    // Wall break in the startOfFrame cycle, then a repeat in the same frame.
    drive(1, 0, 0, 1, 0, 1, 2'b00); #1;
    chk("blast_wall_comb", 32'(collision_blast_wall), 1);
    cyc();
    chk("wall_sof_pulse", 32'(wall_pulse), 1);
    drive(0, 0, 0, 1, 0, 1, 2'b00); cyc();
    chk("wall_repeat_frame", 32'(wall_pulse), 0);
    drive(0, 0, 0, 0, 0, 0, 2'b00); cyc();

    // Asynchronous reset while invulnerable.
    resetN = 1'b0; #1;
    resetN = 1'b1;
    cyc();
    drive(0, 1, 0, 0, 0, 0, 2'b10); cyc();
    chk("rst_seq_hit", 32'(hit_pulse), 1);
    chk("rst_seq_invuln", 32'(invuln), 1);
    drive(0, 0, 0, 0, 0, 0, 2'b00); #3;
    resetN = 1'b0; #1;
    chk("midinv_rst_lives", 32'(lives), 3);
    chk("midinv_rst_invuln", 32'(invuln), 0);
    chk("midinv_rst_game_over", 32'(game_over), 0);
    chk("midinv_rst_kill_count", 32'(kill_count), 0);
    resetN = 1'b1;
    cyc();
    chk("post_rst_alive", 32'(invuln), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
